// File: rtl/ll_head_table_stage_if.sv
// Command bus for the head-table stage: upstream commands, engine commands, and the
// engine's head-table write-back / result-done strobes.
interface ll_head_table_stage_if #(
  parameter int unsigned BUCKET_WIDTH = 8,
  parameter int unsigned KEY_WIDTH    = 32,
  parameter int unsigned PTR_WIDTH    = 10
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [KEY_WIDTH-1:0]    cmd_key;
  logic [1:0]              cmd_opcode;
  logic [BUCKET_WIDTH-1:0] cmd_bucket;

  logic                    ll_cmd_valid;
  logic                    ll_cmd_ready;
  logic [KEY_WIDTH-1:0]    ll_cmd_key;
  logic [1:0]              ll_cmd_opcode;
  logic [PTR_WIDTH-1:0]    ll_cmd_head_ptr;
  logic                    ll_cmd_head_ptr_val;

  logic [PTR_WIDTH-1:0]    ht_wr_data_ptr;
  logic                    ht_wr_data_ptr_val;
  logic                    ht_wr_en;
  logic                    res_done;

  modport master (
    output cmd_valid, cmd_key, cmd_opcode, cmd_bucket, ll_cmd_ready,
           ht_wr_data_ptr, ht_wr_data_ptr_val, ht_wr_en, res_done,
    input  cmd_ready, ll_cmd_valid, ll_cmd_key, ll_cmd_opcode, ll_cmd_head_ptr,
           ll_cmd_head_ptr_val
  );

  modport slave (
    input  cmd_valid, cmd_key, cmd_opcode, cmd_bucket, ll_cmd_ready,
           ht_wr_data_ptr, ht_wr_data_ptr_val, ht_wr_en, res_done,
    output cmd_ready, ll_cmd_valid, ll_cmd_key, ll_cmd_opcode, ll_cmd_head_ptr,
           ll_cmd_head_ptr_val
  );
endinterface

// File: rtl/ll_head_table_stage.sv
// Per-bucket head-pointer table in front of the linked-list engine; one command in flight.
// Define LL_HT_OCCUPANCY_EN to add bucket_used_cnt_o (count of non-empty buckets).
module ll_head_table_stage #(
  parameter int unsigned BUCKET_WIDTH = 8,
  parameter int unsigned KEY_WIDTH    = 32,
  parameter int unsigned PTR_WIDTH    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ll_head_table_stage_if.slave  bus,
  output logic                  init_done_o
`ifdef LL_HT_OCCUPANCY_EN
  ,
  output logic [BUCKET_WIDTH:0] bucket_used_cnt_o
`endif
);

  localparam int unsigned Depth = 2 ** BUCKET_WIDTH;

  localparam logic [1:0] OpInsert = 2'd0;
  localparam logic [1:0] OpDelete = 2'd1;
  localparam logic [1:0] OpDeq    = 2'd2;

  localparam logic [2:0] StInit    = 3'd0;
  localparam logic [2:0] StIdle    = 3'd1;
  localparam logic [2:0] StRead    = 3'd2;
  localparam logic [2:0] StIssue   = 3'd3;
  localparam logic [2:0] StWaitRes = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [BUCKET_WIDTH-1:0] sweep_q;
  logic [BUCKET_WIDTH-1:0] bucket_q;
  logic [KEY_WIDTH-1:0]    key_q;
  logic [1:0]              opcode_q;
  logic [PTR_WIDTH-1:0]    head_ptr_q;
  logic                    head_val_q;
  logic                    init_done_q;

  // Entry layout: {ptr, val}
  logic [PTR_WIDTH:0]      mem [Depth];
  logic [PTR_WIDTH:0]      rd_data_q;

  logic                    op_ok;
  logic                    accept;
  logic                    wr_en;
  logic [BUCKET_WIDTH-1:0] wr_addr;
  logic [PTR_WIDTH:0]      wr_data;

  assign op_ok  = (bus.cmd_opcode == OpInsert) || (bus.cmd_opcode == OpDelete) ||
                  (bus.cmd_opcode == OpDeq);
  assign accept = (state_q == StIdle) && bus.cmd_valid && op_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit:    if (sweep_q == '1) state_d = StIdle;
      StIdle:    if (accept) state_d = StRead;
      StRead:    state_d = StIssue;
      StIssue:   if (bus.ll_cmd_ready) state_d = StWaitRes;
      StWaitRes: if (bus.res_done) state_d = StIdle;
      default:   state_d = StInit;
    endcase
  end

  // Sweep owns the write port during INIT; engine write-backs are ignored there.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bucket_q;
    wr_data = {bus.ht_wr_data_ptr, bus.ht_wr_data_ptr_val};
    if (state_q == StInit) begin
      wr_en   = 1'b1;
      wr_addr = sweep_q;
      wr_data = '0;
    end else if (bus.ht_wr_en) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (accept) rd_data_q <= mem[bus.cmd_bucket];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      bucket_q    <= '0;
      key_q       <= '0;
      opcode_q    <= '0;
      head_ptr_q  <= '0;
      head_val_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StInit) begin
        sweep_q <= sweep_q + 1'b1;
        if (sweep_q == '1) init_done_q <= 1'b1;
      end
      if (accept) begin
        key_q    <= bus.cmd_key;
        opcode_q <= bus.cmd_opcode;
        bucket_q <= bus.cmd_bucket;
      end
      if (state_q == StRead) {head_ptr_q, head_val_q} <= rd_data_q;
    end
  end

  assign bus.cmd_ready           = (state_q == StIdle);
  assign bus.ll_cmd_valid        = (state_q == StIssue);
  assign bus.ll_cmd_key          = key_q;
  assign bus.ll_cmd_opcode       = opcode_q;
  assign bus.ll_cmd_head_ptr     = head_ptr_q;
  assign bus.ll_cmd_head_ptr_val = head_val_q;
  assign init_done_o             = init_done_q;

`ifdef LL_HT_OCCUPANCY_EN
  localparam logic [BUCKET_WIDTH:0] CntMax = (BUCKET_WIDTH + 1)'(Depth);

  logic [BUCKET_WIDTH:0] cnt_q;
  logic                  track_q;
  logic                  old_val;

  // A write-back landing in READ must compare against the value just read.
  assign old_val = (state_q == StRead) ? rd_data_q[0] : track_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      track_q <= 1'b0;
    end else if (state_q == StInit) begin
      cnt_q   <= '0;
      track_q <= 1'b0;
    end else if (bus.ht_wr_en) begin
      track_q <= bus.ht_wr_data_ptr_val;
      if (!old_val && bus.ht_wr_data_ptr_val && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (old_val && !bus.ht_wr_data_ptr_val && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end else if (state_q == StRead) begin
      track_q <= rd_data_q[0];
    end
  end

  assign bucket_used_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_ll_head_table_stage.sv
// Randomised bench for ll_head_table_stage: table model + expected-issue queue,
// with a negedge monitor comparing every presented engine command.
module tb_ll_head_table_stage;
  localparam int BW    = 8;
  localparam int KW    = 32;
  localparam int PW    = 10;
  localparam int Depth = 1 << BW;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [1:0]    op;
    logic [PW-1:0] ptr;
    logic          val;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic init_done;
`ifdef LL_HT_OCCUPANCY_EN
  logic [BW:0] used_cnt;
`endif

  always #5 clk_i = ~clk_i;

  ll_head_table_stage_if #(.BUCKET_WIDTH(BW), .KEY_WIDTH(KW), .PTR_WIDTH(PW)) bus ();

  ll_head_table_stage #(.BUCKET_WIDTH(BW), .KEY_WIDTH(KW), .PTR_WIDTH(PW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .init_done_o (init_done)
`ifdef LL_HT_OCCUPANCY_EN
    ,
    .bucket_used_cnt_o (used_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  exp_t          exp_q[$];
  logic [PW-1:0] m_ptr[Depth];
  bit            m_val[Depth];
  logic [BW-1:0] cur_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_occ();
`ifdef LL_HT_OCCUPANCY_EN
    int n = 0;
    for (int i = 0; i < Depth; i++) n += int'(m_val[i]);
    check("bucket_used_cnt", used_cnt, n);
`endif
  endtask

  // Monitor: every presented engine command must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && bus.ll_cmd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 1, 0);
      end else begin
        check("issue_key", bus.ll_cmd_key, exp_q[0].key);
        check("issue_opcode", bus.ll_cmd_opcode, exp_q[0].op);
        check("issue_head_ptr", bus.ll_cmd_head_ptr, exp_q[0].ptr);
        check("issue_head_val", bus.ll_cmd_head_ptr_val, exp_q[0].val);
        check("cmd_ready_low_while_issuing", bus.cmd_ready, 0);
        if (bus.ll_cmd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    bus.cmd_valid          = 1'b0;
    bus.cmd_key            = '0;
    bus.cmd_opcode         = '0;
    bus.cmd_bucket         = '0;
    bus.ll_cmd_ready       = 1'b0;
    bus.ht_wr_data_ptr     = '0;
    bus.ht_wr_data_ptr_val = 1'b0;
    bus.ht_wr_en           = 1'b0;
    bus.res_done           = 1'b0;
  endtask

  task automatic do_reset();
    int  lat  = 0;
    bit  rdy  = 1'b0;
    rst_i = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ll_cmd_valid", bus.ll_cmd_valid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_key", bus.ll_cmd_key, 0);
    check("rst_opcode", bus.ll_cmd_opcode, 0);
    check("rst_head_ptr", {bus.ll_cmd_head_ptr, bus.ll_cmd_head_ptr_val}, 0);
    check("rst_init_done", init_done, 0);
    for (int i = 0; i < Depth; i++) begin
      m_ptr[i] = '0;
      m_val[i] = 1'b0;
    end
    exp_q.delete();
    rst_i = 1'b0;
    for (int k = 1; k <= Depth + 10; k++) begin
      @(posedge clk_i);
      #1;
      if (init_done) begin
        lat = k;
        break;
      end
      if (bus.cmd_ready) rdy = 1'b1;
    end
    check("init_latency", lat, Depth);
    check("cmd_ready_before_init", rdy, 0);
    check("cmd_ready_after_init", bus.cmd_ready, 1);
    check_occ();
  endtask

  task automatic send_cmd(input logic [KW-1:0] key, input logic [1:0] op,
                          input logic [BW-1:0] b);
    int   n = 0;
    exp_t e;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("cmd_ready_timeout", n < 50, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_key    = key;
    bus.cmd_opcode = op;
    bus.cmd_bucket = b;
    if (op != 2'b11) begin
      e.key = key;
      e.op  = op;
      e.ptr = m_ptr[b];
      e.val = m_val[b];
      exp_q.push_back(e);
      cur_b = b;
    end
    @(posedge clk_i);
    #1;
    bus.cmd_valid = 1'b0;
    if (op == 2'b11) begin
      check("invalid_op_stays_idle", bus.cmd_ready, 1);
    end else begin
      check("valid_low_at_n_plus_1", bus.ll_cmd_valid, 0);
      @(posedge clk_i);
      #1;
      check("valid_high_at_n_plus_2", bus.ll_cmd_valid, 1);
    end
  endtask

  task automatic handshake(input int stall);
    repeat (stall) begin
      @(posedge clk_i);
      #1;
    end
    bus.ll_cmd_ready = 1'b1;
    @(posedge clk_i);
    #1;
    bus.ll_cmd_ready = 1'b0;
  endtask

  task automatic wb(input logic [PW-1:0] p, input bit v, input bit done);
    bus.ht_wr_en           = 1'b1;
    bus.ht_wr_data_ptr     = p;
    bus.ht_wr_data_ptr_val = v;
    bus.res_done           = done;
    m_ptr[cur_b] = p;
    m_val[cur_b] = v;
    @(posedge clk_i);
    #1;
    bus.ht_wr_en = 1'b0;
    bus.res_done = 1'b0;
    check_occ();
  endtask

  task automatic finish_cmd();
    bus.res_done = 1'b1;
    @(posedge clk_i);
    #1;
    bus.res_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cur_b = '0;
    #1;
    do_reset();

    // Occupancy: insert buckets 1 and 2, then empty bucket 1.
    send_cmd(32'h11, 2'd0, 8'd1); handshake(0); wb(10'd9, 1'b1, 1'b1);
    send_cmd(32'h22, 2'd0, 8'd2); handshake(0); wb(10'd8, 1'b1, 1'b1);
    send_cmd(32'h33, 2'd1, 8'd1); handshake(0); wb(10'd0, 1'b0, 1'b1);

    // Bucket 5 insert, then re-read sees the written head.
    send_cmd(32'h1234, 2'd0, 8'd5); handshake(1); wb(10'd3, 1'b1, 1'b0); finish_cmd();
    send_cmd(32'h5678, 2'd2, 8'd5); handshake(10); finish_cmd();

    // Invalid opcode on a populated bucket leaves it intact.
    send_cmd(32'h77, 2'd0, 8'd7); handshake(0); wb(10'h2a, 1'b1, 1'b1);
    send_cmd(32'hdead, 2'b11, 8'd7);
    repeat (5) @(posedge clk_i);
    #1;
    send_cmd(32'h99, 2'd2, 8'd7); handshake(2); finish_cmd();

    // Reset while waiting for the result.
    send_cmd(32'haa, 2'd0, 8'd5); handshake(0); wb(10'd4, 1'b1, 1'b0);
    do_reset();
    send_cmd(32'hbb, 2'd2, 8'd5); handshake(0); finish_cmd();

    for (int i = 0; i < 60; i++) begin
      logic [1:0]    op;
      logic [BW-1:0] b;
      int            nw;
      bit            done;
      op   = 2'($urandom_range(0, 3));
      b    = BW'($urandom_range(0, 7));
      send_cmd($urandom, op, b);
      if (op != 2'b11) begin
        handshake($urandom_range(0, 3));
        nw   = $urandom_range(0, 2);
        done = 1'b0;
        for (int w = 0; w < nw; w++) begin
          bit last_done;
          last_done = (w == nw - 1) && ($urandom_range(0, 1) == 1);
          wb(PW'($urandom), 1'($urandom), last_done);
          done = last_done;
        end
        if (!done) finish_cmd();
      end
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end

    repeat (4) @(posedge clk_i);
    #1;
    check("expected_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
